// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target for the multicycle RV32I core.
// Accepts one read or write, waits LATENCY cycles, performs the byte-masked
// write or the word read, and then pulses mem_resp for a single cycle.
// Optional feature macro: MEM_RESPONDER_ERR_EN adds the mem_err output.
// Misaligned, out-of-range and read+write requests are then flagged and
// have no effect on the array or on mem_rdata.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic        mem_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CountStart = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic [3:0] r_count;
  logic [3:0] w_countNext;

  // Request captured at the accept edge; the initiator may change its lines afterwards.
  logic [31:0] r_reqAddr;
  logic [31:0] r_reqWdata;
  logic [3:0]  r_reqBe;
  logic        r_reqWrite;
`ifdef MEM_RESPONDER_ERR_EN
  logic        r_reqErr;
`endif

  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_doAccess;
  logic [31:0]           w_accAddr;
  logic [31:0]           w_accWdata;
  logic [3:0]            w_accBe;
  logic                  w_accWrite;
  logic                  w_accErr;
  logic                  w_liveErr;
  logic [DEPTH_LOG2-1:0] w_wordIdx;
  logic                  w_unused;

  assign w_accept = (r_state == IDLE) && (mem_read || mem_write);

  // A request is malformed if it asks for both ops, is misaligned or lies beyond the array.
`ifdef MEM_RESPONDER_ERR_EN
  assign w_liveErr = (mem_read && mem_write) || (|mem_address[1:0]) ||
                     ((mem_address >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
  assign w_liveErr = 1'b0;
`endif

  // With LATENCY=1 the access happens on the accept edge itself, so it uses the live inputs.
  always_comb begin
    w_accAddr  = r_reqAddr;
    w_accWdata = r_reqWdata;
    w_accBe    = r_reqBe;
    w_accWrite = r_reqWrite;
    w_accErr   = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
    w_accErr   = r_reqErr;
`endif
    if (r_state == IDLE) begin
      w_accAddr  = mem_address;
      w_accWdata = mem_wdata;
      w_accBe    = mem_byte_enable;
      w_accWrite = mem_write;
      w_accErr   = w_liveErr;
    end
  end

  // The upper and lower address bits are dropped here, so addresses alias and wrap.
  assign w_wordIdx = w_accAddr[DEPTH_LOG2+1:2];
  assign w_unused  = ^w_accAddr;

  // The access fires on whichever edge moves the FSM into RESP.
  assign w_doAccess = ((r_state == BUSY) && (r_count == 4'd1)) ||
                      (w_accept && (LATENCY == 1));

  // Next-state and latency counter: IDLE -> BUSY (count down) -> RESP -> IDLE.
  always_comb begin
    w_nextState = r_state;
    w_countNext = r_count;
    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (LATENCY == 1) begin
            w_nextState = RESP;
            w_countNext = 4'd0;
          end else begin
            w_nextState = BUSY;
            w_countNext = CountStart;
          end
        end
      end
      BUSY: begin
        w_countNext = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        w_countNext = 4'd0;
      end
    endcase
  end

  // Control state, captured request and read data register; reset abandons any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_reqAddr  <= 32'd0;
      r_reqWdata <= 32'd0;
      r_reqBe    <= 4'd0;
      r_reqWrite <= 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
      r_reqErr   <= 1'b0;
`endif
      r_rdata    <= 32'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_countNext;
      if (w_accept) begin
        r_reqAddr  <= mem_address;
        r_reqWdata <= mem_wdata;
        r_reqBe    <= mem_byte_enable;
        r_reqWrite <= mem_write;
`ifdef MEM_RESPONDER_ERR_EN
        r_reqErr   <= w_liveErr;
`endif
      end
      if (w_doAccess && !w_accWrite && !w_accErr) begin
        r_rdata <= r_mem[w_wordIdx];
      end
    end
  end

  // Backing array: byte-masked write, held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && w_doAccess && w_accWrite && !w_accErr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_accBe[i]) begin
          r_mem[w_wordIdx][8*i +: 8] <= w_accWdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_resp  = (r_state == RESP);
`ifdef MEM_RESPONDER_ERR_EN
  assign mem_err   = (r_state == RESP) && r_reqErr;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with LATENCY=3 (index 0)
// and one with LATENCY=1 (index 1), both with DEPTH_LOG2=8.
module tb_mem_responder;

  logic        clk;
  logic        rst     [2];
  logic        rdIn    [2];
  logic        wrIn    [2];
  logic [3:0]  beIn    [2];
  logic [31:0] addrIn  [2];
  logic [31:0] wdIn    [2];
  logic [31:0] rdOut   [2];
  logic        respOut [2];
`ifdef MEM_RESPONDER_ERR_EN
  logic        errOut  [2];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: plain word array per instance plus the last value read.
  logic [31:0] modelMem [2][256];
  logic [31:0] lastRd   [2];

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst[0]), .mem_read(rdIn[0]), .mem_write(wrIn[0]),
    .mem_byte_enable(beIn[0]), .mem_address(addrIn[0]), .mem_wdata(wdIn[0]),
    .mem_rdata(rdOut[0]), .mem_resp(respOut[0])
`ifdef MEM_RESPONDER_ERR_EN
    , .mem_err(errOut[0])
`endif
  );

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[1]), .mem_read(rdIn[1]), .mem_write(wrIn[1]),
    .mem_byte_enable(beIn[1]), .mem_address(addrIn[1]), .mem_wdata(wdIn[1]),
    .mem_rdata(rdOut[1]), .mem_resp(respOut[1])
`ifdef MEM_RESPONDER_ERR_EN
    , .mem_err(errOut[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          hold;
    logic [31:0] expRd;
    bit          expErr;
  } vec_t;

  vec_t vecs [11];

  function automatic int latOf(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Apply the specification's rules directly to the model and predict the outputs.
  task automatic modelApply(input int d, input bit rd, input bit wr, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] expRd, output bit expErr);
    int idx;
    idx = int'((addr / 4) % 256);
    expErr = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
    expErr = (rd && wr) || (addr % 4 != 0) || (addr >= 32'd1024);
`endif
    if (!expErr) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) modelMem[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        lastRd[d] = modelMem[d][idx];
      end
    end
    expRd = lastRd[d];
  endtask

  task automatic clearInputs(input int d);
    rdIn[d]   = 1'b0;
    wrIn[d]   = 1'b0;
    beIn[d]   = 4'd0;
    addrIn[d] = 32'd0;
    wdIn[d]   = 32'd0;
  endtask

  // Drive one request, wait (bounded) for mem_resp, then confirm the pulse is one cycle wide.
  task automatic applyStimulus(input int d, input bit rd, input bit wr, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input bit hold, input bit drop,
                               output int n, output logic [31:0] gotRd,
                               output logic gotErr, output int respCyc);
    bit seen;
    seen = 1'b0; n = 0; gotRd = 32'd0; gotErr = 1'b0; respCyc = 0;
    @(negedge clk);
    rdIn[d] = rd; wrIn[d] = wr; beIn[d] = be; addrIn[d] = addr; wdIn[d] = wd;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (respOut[d]) begin
        seen = 1'b1; n = k; gotRd = rdOut[d]; respCyc = cyc;
`ifdef MEM_RESPONDER_ERR_EN
        gotErr = errOut[d];
`endif
      end else if (drop && k == 1) begin
        @(negedge clk);
        rdIn[d] = 1'b0; wrIn[d] = 1'b0; addrIn[d] = $urandom;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL timeout dut%0d got=no mem_resp required=mem_resp within 40 cycles", d);
      clearInputs(d);
      return;
    end
    if (!hold) begin
      @(negedge clk);
      clearInputs(d);
    end
    @(posedge clk); #1;
    checkOutput("resp one cycle", {31'd0, respOut[d]}, 32'd0);
`ifdef MEM_RESPONDER_ERR_EN
    checkOutput("err outside resp", {31'd0, errOut[d]}, 32'd0);
`endif
    if (hold) begin
      @(negedge clk);
      clearInputs(d);
    end
  endtask

  // Run one transaction and compare latency, read data and error flag against the model.
  task automatic runChecked(input string name, input int d, input bit rd, input bit wr,
                            input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd,
                            input bit drop, output int respCyc);
    logic [31:0] expRd, gotRd;
    bit expErr;
    logic gotErr;
    int n;
    modelApply(d, rd, wr, be, addr, wd, expRd, expErr);
    applyStimulus(d, rd, wr, be, addr, wd, 1'b0, drop, n, gotRd, gotErr, respCyc);
    if (n != 0) begin
      checkOutput({name, " latency"}, n, latOf(d));
      checkOutput({name, " rdata"}, gotRd, expRd);
`ifdef MEM_RESPONDER_ERR_EN
      checkOutput({name, " err"}, {31'd0, gotErr}, {31'd0, expErr});
`endif
    end
  endtask

  initial begin
    int c1, c2, c3, n;
    logic [31:0] gotRd, expRd;
    logic gotErr;
    bit expErr, anyResp;

    #1_000_000;
    $display("[TB] FAIL watchdog got=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1, c2, c3, n, d, idx, r, op;
    logic [31:0] gotRd, expRd, addr;
    logic gotErr;
    bit expErr, anyResp;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      clearInputs(i);
      lastRd[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset resp", {31'd0, respOut[i]}, 32'd0);
      checkOutput("reset rdata", rdOut[i], 32'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Known contents for word indices 0..16 of both instances.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w <= 16; w++) begin
        runChecked("preload", i, 1'b0, 1'b1, 4'hF, 32'(w * 4), 32'h5000_0000 + 32'(w), 1'b0, c1);
      end
    end

    vecs[0] = '{1'b1, 1'b0, 4'hF, 32'h10,  32'h0,         1'b1, 32'h5000_0004, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'hF, 32'h20,  32'hDEAD_BEEF, 1'b0, 32'h5000_0004, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'h2, 32'h20,  32'h0000_1200, 1'b0, 32'h5000_0004, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h20,  32'h0,         1'b0, 32'hDEAD_12EF, 1'b0};
`ifdef MEM_RESPONDER_ERR_EN
    vecs[4] = '{1'b0, 1'b1, 4'hF, 32'h404, 32'h1122_3344, 1'b0, 32'hDEAD_12EF, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h4,   32'h0,         1'b0, 32'h5000_0001, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 4'hF, 32'h30,  32'h1234_5678, 1'b0, 32'h5000_0001, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 4'hF, 32'h30,  32'h0,         1'b0, 32'h5000_000C, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 4'hF, 32'h33,  32'h0,         1'b0, 32'h5000_000C, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 4'h9, 32'h10,  32'hAABB_CCDD, 1'b0, 32'h5000_000C, 1'b0};
`else
    vecs[4] = '{1'b0, 1'b1, 4'hF, 32'h404, 32'h1122_3344, 1'b0, 32'hDEAD_12EF, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h4,   32'h0,         1'b0, 32'h1122_3344, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 4'hF, 32'h30,  32'h1234_5678, 1'b0, 32'h1122_3344, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 4'hF, 32'h30,  32'h0,         1'b0, 32'h1234_5678, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 4'hF, 32'h33,  32'h0,         1'b0, 32'h1234_5678, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 4'h9, 32'h10,  32'hAABB_CCDD, 1'b0, 32'h1234_5678, 1'b0};
`endif
    vecs[10] = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h0,         1'b0, 32'hAA00_00DD, 1'b0};

    for (int v = 0; v < 11; v++) begin
      modelApply(0, vecs[v].rd, vecs[v].wr, vecs[v].be, vecs[v].addr, vecs[v].wd, expRd, expErr);
      applyStimulus(0, vecs[v].rd, vecs[v].wr, vecs[v].be, vecs[v].addr, vecs[v].wd,
                    vecs[v].hold, 1'b0, n, gotRd, gotErr, c1);
      if (n != 0) begin
        checkOutput($sformatf("vec%0d latency", v), n, 3);
        checkOutput($sformatf("vec%0d rdata", v), gotRd, vecs[v].expRd);
`ifdef MEM_RESPONDER_ERR_EN
        checkOutput($sformatf("vec%0d err", v), {31'd0, gotErr}, {31'd0, vecs[v].expErr});
`endif
      end
    end

    // Request dropped and address changed during BUSY: original access still completes.
    runChecked("drop in busy", 0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, c1);

    // Reset for one cycle during the BUSY phase of a write.
    runChecked("pre-reset read", 0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, c1);
    @(negedge clk);
    wrIn[0] = 1'b1; beIn[0] = 4'hF; addrIn[0] = 32'h40; wdIn[0] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    checkOutput("mid reset rdata", rdOut[0], 32'd0);
    checkOutput("mid reset resp", {31'd0, respOut[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    clearInputs(0);
    anyResp = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (respOut[0]) anyResp = 1'b1;
    end
    checkOutput("abandoned access resp", {31'd0, anyResp}, 32'd0);
    lastRd[0] = 32'd0;
    runChecked("read after reset", 0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, c1);

    // LATENCY=1 back-to-back fetch-style sequence.
    runChecked("b2b read0", 1, 1'b1, 1'b0, 4'hF, 32'h8,  32'h0,         1'b0, c1);
    runChecked("b2b read1", 1, 1'b1, 1'b0, 4'hF, 32'hC,  32'h0,         1'b0, c2);
    runChecked("b2b write", 1, 1'b0, 1'b1, 4'hF, 32'h14, 32'h7777_8888, 1'b0, c3);
    checkOutput("b2b spacing 1", c2 - c1, 32'd2);
    checkOutput("b2b spacing 2", c3 - c2, 32'd2);
    runChecked("b2b readback", 1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 1'b0, c1);

    // Randomized traffic on both instances, including aliased and misaligned addresses.
    for (int i = 0; i < 120; i++) begin
      d = i % 2;
      idx = $urandom_range(0, 15);
      addr = 32'(idx * 4);
      r = $urandom_range(0, 9);
      if (r == 0) addr = addr | 32'($urandom_range(1, 3));
      if (r == 1) addr = addr | (32'h400 << $urandom_range(0, 21));
      op = $urandom_range(0, 9);
      runChecked($sformatf("rand%0d", i), d, (op < 4) || (op == 9), (op >= 4),
                 4'($urandom_range(0, 15)), addr, $urandom, 1'b0, c1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
